// File: rtl/burst_memory.sv
// Byte-addressable big-endian burst memory (1/4/8/16-word bursts, auto-incrementing word address).
// Optional feature macro: MEM_BOUNDS_CHECK_EN adds an error output and rejects out-of-range commands.
module burst_memory #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_BYTES = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic                  error,
`endif
  output logic                  data_valid
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int BSH         = $clog2(BYTES);
  localparam int DEPTH_WORDS = DEPTH_BYTES / BYTES;
  localparam int WAW         = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            count_reg, count_next;
  logic [WAW-1:0]        word_reg, word_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;

  logic                  mem_we;
  logic                  mem_re;
  logic [WAW-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] offset;
  logic [WAW-1:0]        start_idx;
  logic [3:0]            beats_m1;

  // Truncating the word index to WAW bits gives the modulo-DEPTH_BYTES wrap.
  assign offset    = address - START_ADDR;
  assign start_idx = WAW'(offset >> BSH);

  always_comb begin
    beats_m1 = 4'd0;
    case (access_size)
      2'b00:   beats_m1 = 4'd0;
      2'b01:   beats_m1 = 4'd3;
      2'b10:   beats_m1 = 4'd7;
      default: beats_m1 = 4'd15;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] START_W    = {1'b0, START_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_W    = START_W + (ADDR_WIDTH+1)'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0] BYTES_M1_W = (ADDR_WIDTH+1)'(BYTES - 1);

  logic [ADDR_WIDTH:0] first_byte;
  logic [ADDR_WIDTH:0] last_byte;
  logic                in_range;
  logic                reject;
  logic                error_reg;

  // One extra bit keeps the comparison honest near the top of the address space.
  assign first_byte = {1'b0, address};
  assign last_byte  = first_byte + ((ADDR_WIDTH+1)'(beats_m1) << BSH) + BYTES_M1_W;
  assign in_range   = (first_byte >= START_W) && (last_byte < LIMIT_W);
  assign error      = error_reg;
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    word_next  = word_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = word_reg;
`ifdef MEM_BOUNDS_CHECK_EN
    reject     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (enable) begin
`ifdef MEM_BOUNDS_CHECK_EN
          if (!in_range) begin
            reject = 1'b1;
          end else
`endif
          begin
            mem_idx   = start_idx;
            mem_we    = !rw;
            mem_re    = rw;
            word_next = start_idx + WAW'(1);
            if (beats_m1 != 4'd0) begin
              count_next = beats_m1 - 4'd1;
              state_next = rw ? RD_BURST : WR_BURST;
            end
          end
        end
      end
      WR_BURST, RD_BURST: begin
        mem_we    = (state_reg == WR_BURST);
        mem_re    = (state_reg == RD_BURST);
        word_next = word_reg + WAW'(1);
        if (count_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= 4'd0;
      word_reg       <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      error_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      word_reg       <= word_next;
      data_valid_reg <= mem_re;
      if (mem_re) begin
        data_out_reg <= rd_word;
      end
`ifdef MEM_BOUNDS_CHECK_EN
      error_reg      <= reject;
`endif
    end
  end

  // One byte-wide array per lane; lane 0 holds the most significant byte (lowest address).
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
          lane_mem[mem_idx] <= data_in[DATA_WIDTH-1-8*gi -: 8];
        end
      end

      assign rd_word[DATA_WIDTH-1-8*gi -: 8] = lane_mem[mem_idx];
    end
  endgenerate

  assign busy       = (state_reg != IDLE);
  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;

endmodule

// File: tb/tb_burst_memory.sv
// Directed testbench for burst_memory: bursts, mid-burst input changes, reset abort, wrap / bounds check.
module tb_burst_memory;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] S     = 32'h80020000;

  logic          clock;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [1:0]    access_size;
  logic          rw;
  logic          enable;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
`ifdef MEM_BOUNDS_CHECK_EN
  logic          error;
`endif

  int compared   = 0;
  int mismatched = 0;

  burst_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_BYTES(DEPTH),
    .START_ADDR (S)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .data_in    (data_in),
    .access_size(access_size),
    .rw         (rw),
    .enable     (enable),
    .busy       (busy),
    .data_out   (data_out),
`ifdef MEM_BOUNDS_CHECK_EN
    .error      (error),
`endif
    .data_valid (data_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cmd(input logic r, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    enable      = 1'b1;
    rw          = r;
    address     = a;
    access_size = sz;
    data_in     = d;
    $display("cmd %s addr=%h size=%0d data=%h", r ? "RD" : "WR", a, sz, d);
  endtask

  initial begin
    int bc;
    int vc;
    reset = 1'b1; enable = 1'b0; rw = 1'b0; address = '0; data_in = '0; access_size = 2'b00;
    @(negedge clock);
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    check("rst_dout", data_out, 0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("rst_error", error, 0);
`endif
    reset = 1'b0;

    // Single word write then read
    cmd(1'b0, S, 2'b00, 32'hDEADBEEF); tick(); enable = 1'b0;
    check("w1_busy", busy, 0);
    cmd(1'b1, S, 2'b00, 32'h0); tick(); enable = 1'b0;
    check("r1_valid", data_valid, 1);
    check("r1_dout", data_out, 32'hDEADBEEF);
    check("r1_busy", busy, 0);
    check("r1_byte0", data_out[31:24], 8'hDE);
    check("r1_byte1", data_out[23:16], 8'hAD);
    check("r1_byte2", data_out[15:8], 8'hBE);
    check("r1_byte3", data_out[7:0], 8'hEF);
    tick();
    check("r1_valid_off", data_valid, 0);
    check("r1_hold", data_out, 32'hDEADBEEF);

    // 4-word write burst, then 8-word read over it
    cmd(1'b0, S + 32'h10, 2'b01, 32'h11111111);
    bc = 0;
    for (int k = 0; k < 4; k++) begin
      data_in = 32'h11111111 * (k + 1);
      tick(); enable = 1'b0;
      if (busy) bc++;
    end
    check("w4_busy_cycles", bc, 3);
    cmd(1'b1, S + 32'h10, 2'b10, 32'h0);
    bc = 0; vc = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); enable = 1'b0;
      if (busy) bc++;
      if (data_valid) vc++;
      if (k < 4) check("r8_data", data_out, 32'h11111111 * (k + 1));
    end
    check("r8_busy_cycles", bc, 7);
    check("r8_valid_cycles", vc, 8);
    tick();
    check("r8_valid_off", data_valid, 0);

    // 16-word write with garbage on the command inputs while busy
    cmd(1'b0, S + 32'h100, 2'b11, 32'hA0000000);
    bc = 0;
    for (int k = 0; k < 16; k++) begin
      data_in = 32'hA0000000 + k;
      tick();
      if (busy) bc++;
      if (k < 15) begin
        enable = (k % 3 != 0); address = S; rw = k[0]; access_size = 2'b00;
      end else begin
        cmd(1'b1, S + 32'h100, 2'b11, 32'h0);
      end
    end
    check("w16_busy_cycles", bc, 15);
    vc = 0;
    for (int j = 0; j < 16; j++) begin
      tick(); enable = 1'b0;
      if (data_valid) vc++;
      check("r16_data", data_out, 32'hA0000000 + j);
    end
    check("r16_valid_cycles", vc, 16);
    cmd(1'b1, S, 2'b00, 32'h0); tick(); enable = 1'b0;
    check("w16_ignored_cmds", data_out, 32'hDEADBEEF);

    // Reset in the middle of an 8-word write
    cmd(1'b0, S + 32'h200, 2'b10, 32'h55550000);
    for (int k = 0; k < 8; k++) begin
      data_in = 32'h55550000 + k;
      tick(); enable = 1'b0;
    end
    cmd(1'b0, S + 32'h200, 2'b10, 32'h66660000);
    for (int k = 0; k < 3; k++) begin
      data_in = 32'h66660000 + k;
      tick(); enable = 1'b0;
    end
    reset = 1'b1; data_in = 32'h66660003;
    tick();
    reset = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", data_valid, 0);
    check("rstmid_dout", data_out, 0);
    cmd(1'b1, S + 32'h200, 2'b10, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick(); enable = 1'b0;
      check("rstmid_data", data_out, (k < 3) ? 32'h66660000 + k : 32'h55550000 + k);
    end
    tick();

    // Back-to-back single-word commands
    cmd(1'b0, S + 32'h300, 2'b00, 32'hC0FFEE01); tick();
    cmd(1'b0, S + 32'h304, 2'b00, 32'hC0FFEE02); tick();
    cmd(1'b1, S + 32'h300, 2'b00, 32'h0); tick();
    check("b2b_r0", data_out, 32'hC0FFEE01);
    cmd(1'b1, S + 32'h304, 2'b00, 32'h0); tick(); enable = 1'b0;
    check("b2b_r1", data_out, 32'hC0FFEE02);
    check("b2b_valid", data_valid, 1);
    tick();

`ifndef MEM_BOUNDS_CHECK_EN
    // Write burst that runs off the end of the array wraps to offset 0
    cmd(1'b0, S + 32'(DEPTH) - 32'd8, 2'b01, 32'h77770000);
    for (int k = 0; k < 4; k++) begin
      data_in = 32'h77770000 + k;
      tick(); enable = 1'b0;
    end
    cmd(1'b1, S, 2'b00, 32'h0); tick();
    check("wrap_off0", data_out, 32'h77770002);
    cmd(1'b1, S + 32'h4, 2'b00, 32'h0); tick();
    check("wrap_off4", data_out, 32'h77770003);
    cmd(1'b1, S + 32'(DEPTH) - 32'd8, 2'b00, 32'h0); tick();
    check("wrap_top0", data_out, 32'h77770000);
    cmd(1'b1, S + 32'(DEPTH) - 32'd4, 2'b00, 32'h0); tick(); enable = 1'b0;
    check("wrap_top1", data_out, 32'h77770001);
`else
    // Commands outside the window are consumed with a one-cycle error pulse
    cmd(1'b1, 32'h8001FFFC, 2'b00, 32'h0); tick(); enable = 1'b0;
    check("oob_rd_error", error, 1);
    check("oob_rd_valid", data_valid, 0);
    check("oob_rd_busy", busy, 0);
    tick();
    check("oob_rd_error_off", error, 0);
    cmd(1'b0, S + 32'(DEPTH) - 32'd8, 2'b01, 32'h77770000); tick(); enable = 1'b0;
    check("oob_wr_error", error, 1);
    check("oob_wr_busy", busy, 0);
    for (int k = 1; k < 4; k++) begin
      data_in = 32'h77770000 + k;
      tick();
    end
    cmd(1'b1, S, 2'b00, 32'h0); tick(); enable = 1'b0;
    check("oob_wr_off0", data_out, 32'hDEADBEEF);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
